// File: rtl/mips_pkg.sv
// Shared encodings for the code-memory loader: FSM states and instruction width.
package mips_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and code-memory write bus of the loader; no backpressure on either side.
interface imem_loader_if #(
  parameter int CODE_DIR_WIDTH = 4
);
  import mips_pkg::*;

  logic [7:0]                rx_data;
  logic                      rx_valid;
  logic                      wr_en;
  logic [CODE_DIR_WIDTH-1:0] wr_addr;
  logic [INSTR_WIDTH-1:0]    wr_data;

  modport master (input rx_data, rx_valid, output wr_en, wr_addr, wr_data);
  modport slave  (output rx_data, rx_valid, input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer; word/word_ready are combinational on the 4th byte.
// Latency 0 (caller registers the write); no backpressure, every strobed byte is consumed.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   byte_vld,
  input  logic [7:0]             byte_dat,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_ready
);
  logic [INSTR_WIDTH-9:0] shreg;
  logic [1:0]             cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (byte_vld) begin
      shreg <= {shreg[INSTR_WIDTH-17:0], byte_dat};
      cnt   <= cnt + 2'd1;
    end
  end

  // The first byte of a word ends up in bits 31:24.
  assign word       = {shreg, byte_dat};
  assign word_ready = byte_vld && (cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian image into code memory, holding the CPU in reset meanwhile.
// wr_en one cycle after each 4th byte; no backpressure, an inter-byte timeout aborts the load.
module imem_loader
  import mips_pkg::*;
#(
  parameter int CODE_DIR_WIDTH = 4,
  parameter int CODE_DEPTH     = 16,
  parameter int TO_WIDTH       = 16,
  parameter int TIMEOUT        = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  imem_loader_if.master           bus,
  output logic                    cpu_rst,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [CODE_DIR_WIDTH:0] words_loaded
);
  state_t                  state;
  logic [CODE_DIR_WIDTH:0] n_words;
  logic [TO_WIDTH-1:0]     to_cnt;
  logic [INSTR_WIDTH-1:0]  word;
  logic                    word_ready;
  logic                    start_ok;
  logic                    byte_vld;
  logic                    last_written;
  logic                    timed_out;
  logic                    bad_hdr;

  assign start_ok     = start && (state == IDLE || state == DONE || state == ERR);
  assign last_written = bus.wr_en && (words_loaded == n_words);
  // Once all N words are written, trailing bytes must not feed the packer.
  assign byte_vld     = bus.rx_valid && (state == DATA) && (words_loaded != n_words);
  assign timed_out    = !bus.rx_valid && (to_cnt == TO_WIDTH'(TIMEOUT - 1));
  assign bad_hdr      = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > CODE_DEPTH);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_vld   (byte_vld),
    .byte_dat   (bus.rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      to_cnt       <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            busy         <= 1'b1;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            to_cnt       <= '0;
            bus.wr_addr  <= '0;
          end else if (state == IDLE) begin
            cpu_rst <= 1'b0;
          end
        end
        HDR: begin
          if (bus.rx_valid) begin
            to_cnt <= '0;
            if (bad_hdr) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              n_words <= bus.rx_data[CODE_DIR_WIDTH:0];
              state   <= DATA;
            end
          end else if (timed_out) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA: begin
          if (last_written) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_rst <= 1'b0;
          end else if (timed_out) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            to_cnt <= bus.rx_valid ? '0 : to_cnt + 1'b1;
            if (word_ready) begin
              bus.wr_en    <= 1'b1;
              bus.wr_data  <= word;
              bus.wr_addr  <= words_loaded[CODE_DIR_WIDTH-1:0];
              words_loaded <= words_loaded + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard checked by a negedge monitor.
module tb_imem_loader;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpu_rst, busy, done, err;
  logic [4:0] words_loaded;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  imem_loader_if #(.CODE_DIR_WIDTH(4)) bus ();

  imem_loader #(
    .CODE_DIR_WIDTH(4), .CODE_DEPTH(16), .TO_WIDTH(16), .TIMEOUT(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus.master),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_wr_en", bus.wr_en, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
        chk("wr_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] addr, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31 - 8*i -: 8];
      if (i == 3) sb.push_back('{addr: addr, data: w, cyc: cyc + 1});
      send_byte(b, gap);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // 1: reset values, then cpu_rst drops on the first edge after release
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_words", 32'(words_loaded), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cpu_rst", cpu_rst, 0);
    repeat (5) @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);

    // 2: two-word image on spaced strobes
    pulse_start();
    chk("load_busy", busy, 1);
    chk("load_cpu_rst0", cpu_rst, 1);
    send_byte(8'h02, 2);
    send_word(32'h20010005, 4'd0, 2);
    chk("load_cpu_rst1", cpu_rst, 1);
    send_word(32'h8C020004, 4'd1, 2);
    chk("load_done", done, 1);
    chk("load_cpu_rst_rel", cpu_rst, 0);
    chk("load_busy_end", busy, 0);
    chk("load_words", 32'(words_loaded), 2);
    chk("load_addr_hold", 32'(bus.wr_addr), 1);

    // 3: illegal headers
    pulse_start();
    chk("start_clr_done", done, 0);
    send_byte(8'h00, 0);
    chk("hdr0_err", err, 1);
    chk("hdr0_cpu_rst", cpu_rst, 1);
    chk("hdr0_busy", busy, 0);
    pulse_start();
    send_byte(8'h11, 0);
    chk("hdr17_err", err, 1);
    chk("hdr17_cpu_rst", cpu_rst, 1);
    chk("hdr17_words", 32'(words_loaded), 0);

    // 4: inter-byte timeout, then recovery
    pulse_start();
    chk("start_clr_err", err, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (19) @(negedge clk);
    chk("to_before", err, 0);
    @(negedge clk);
    chk("to_at", err, 1);
    chk("to_cpu_rst", cpu_rst, 1);
    chk("to_words", 32'(words_loaded), 0);
    repeat (3) @(negedge clk);
    pulse_start();
    send_byte(8'h01, 1);
    send_word(32'hDEADBEEF, 4'd0, 1);
    chk("recover_done", done, 1);
    chk("recover_err", err, 0);

    // 5: full 16-word image, back-to-back bytes
    pulse_start();
    send_byte(8'h10, 0);
    for (int k = 0; k < 16; k++) send_word($urandom, 4'(k), 0);
    @(negedge clk);
    chk("full_done", done, 1);
    chk("full_words", 32'(words_loaded), 16);
    chk("full_cpu_rst", cpu_rst, 0);

    // 6: asynchronous reset mid-load, then ignored bytes in IDLE
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'hCAFEF00D, 4'd0, 0);
    send_byte(8'h12, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_words", 32'(words_loaded), 0);
    chk("arst_wr_data", bus.wr_data, 0);
    chk("arst_wr_addr", 32'(bus.wr_addr), 0);
    chk("arst_done_err", {done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) send_byte(8'(k + 1), 1);
    chk("idle_bytes_words", 32'(words_loaded), 0);
    chk("idle_bytes_busy", busy, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the code-memory interface that the pipeline's IF stage reads.
- Takes a byte stream from an external serial receiver (valid-strobed) and assembles big-endian 32-bit instructions.
- Writes the instructions to consecutive code-memory addresses from 0.
- Holds the CPU pipeline in reset while loading and releases it when the image is complete.

Parameters:
- CODE_DIR_WIDTH, 4, code-memory address width.
- CODE_DEPTH, 16, number of instruction words; maximum legal load count.
- TO_WIDTH, 16, width of the inter-byte timeout counter.
- TIMEOUT, 50000, maximum clk cycles allowed between accepted bytes during a load.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  load request pulse; sampled only in IDLE, DONE, ERR.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- wr_en  out  1  code-memory write strobe, one cycle per word.
- wr_addr  out  CODE_DIR_WIDTH  code-memory write address.
- wr_data  out  32  instruction word to write.
- cpu_rst  out  1  pipeline reset request, OR-ed with rst at the SoC top.
- busy  out  1  high in HDR and DATA.
- done  out  1  level: last load completed successfully.
- err  out  1  level: last load aborted.
- words_loaded  out  CODE_DIR_WIDTH+1  words written in the current/last load.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE; wr_en=0; wr_addr=0; wr_data=0.
  - cpu_rst=1 (drops to 0 on the first clk edge after rst deasserts).
  - busy=0; done=0; err=0; words_loaded=0.
  - Byte counter=0; timeout counter=0.
- States: IDLE, HDR, DATA, DONE, ERR. cpu_rst=1 in HDR, DATA, ERR; cpu_rst=0 in IDLE and DONE.
- IDLE/DONE/ERR, start=1:
  - Go to HDR.
  - Clear done, err, words_loaded, byte counter, timeout counter; wr_addr=0.
  - start in any other state is ignored.
  - rx_valid outside HDR/DATA is ignored.
- HDR, rx_valid:
  - Byte is word count N.
  - N=0 or N>CODE_DEPTH -> ERR.
  - Otherwise latch N -> DATA.
- DATA, rx_valid: shift the byte into an assembly register, MSB first (first byte -> bits 31:24); byte counter increments modulo 4.
- On the 4th byte:
  - Next cycle: wr_en=1, wr_data=assembled word, wr_addr=current word index.
  - words_loaded increments in that same cycle.
  - wr_en latency is exactly one cycle after the accepting edge.
- A byte arriving in the same cycle as wr_en is accepted normally; at most one write is in flight.
- After the write of word N-1, the next cycle enters DONE: done=1, cpu_rst=0, busy=0. wr_addr wraps to 0 only on the next start.
- Timeout:
  - In HDR/DATA, the counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT -> ERR; no further writes.
  - Words already written stay in memory.
- ERR: err=1, cpu_rst=1 held until the next start. Prevents running a partial image.
- rst mid-load: immediate return to reset values; a partial image remains in code memory.
- Code memory is write-only from this block; it is not cleared.

Decomposition:
- Shared package (mips_pkg): state encoding constants (IDLE, HDR, DATA, DONE, ERR, 3 bits) and INSTR_WIDTH=32.
- One natural sub-module: imem_word_packer. Byte shift register, 2-bit byte counter, word_ready pulse. The top-level FSM handles header, addressing, timeout and cpu_rst.

Test Plan:
1. Release rst, idle 5 cycles -> cpu_rst=0 from the first edge after release; wr_en never asserted; done=err=0.
2. start; bytes 0x02, 0x20,0x01,0x00,0x05, 0x8C,0x02,0x00,0x04 on spaced rx_valid strobes:
   - wr_en at addr 0 data 0x20010005, then addr 1 data 0x8C020004.
   - Then done=1, cpu_rst=0, words_loaded=2.
   - cpu_rst=1 throughout the load.
3. start; header 0x00 -> ERR, err=1, cpu_rst=1, no wr_en. Repeat with header 0x11 (17 > CODE_DEPTH) -> same response.
4. start; header 0x01, then 2 data bytes, then silence for TIMEOUT cycles (TIMEOUT=20 in bench) -> err=1 exactly at cycle 20, no wr_en. Then start + valid image -> recovers to done=1.
5. Back-to-back rx_valid every cycle for N=16 (64 bytes):
   - 16 wr_en pulses, addresses 0..15, one cycle after each 4th byte.
   - words_loaded=16, done=1.
6. Assert rst after the 5th data byte of a 2-word load -> all outputs return to reset values asynchronously. Bytes sent while in IDLE produce no writes.
